bat_microsequencer: RTL and testbench

- Parametrised, state-machine-driven control unit for the BatAmateur bus CPU. Next generation of the fixed-width uOP-counter controller.
- Decodes the current instruction and sequences PC, MAR, RAM, IR, register file and ALU control strobes over the shared bus.
- Adds register-count and width parameters, a variable-latency memory handshake (MEM_READY), a HALT instruction, and status outputs.

---
 rtl/bat_pkg.sv | 59 +++++
 rtl/bat_instr_decode.sv | 59 +++++
 rtl/bat_microsequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_bat_microsequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bat_pkg.sv
// Shared types and constants for the BatAmateur microsequencer.
package bat_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH_ADDR,
        ST_FETCH_IR,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_HALT
    } state_e;

    // Decoded instruction classes; MOV/INC/HALT are carved out of the ALU space
    typedef enum logic [2:0] {
        CL_ALU,
        CL_MOV,
        CL_INC,
        CL_HALT,
        CL_JMP_DIR,
        CL_LS_DIR,
        CL_JMP_IND,
        CL_LS_IND
    } instr_class_e;

    // Top nibble that selects the ALU class (checked before the 2-bit classes)
    localparam logic [3:0] CLASS_ALU = 4'b0111;

    // 2-bit class codes in the top two instruction bits
    localparam logic [1:0] CLS_JMP_DIR = 2'b01;
    localparam logic [1:0] CLS_LS_DIR  = 2'b00;
    localparam logic [1:0] CLS_JMP_IND = 2'b11;
    localparam logic [1:0] CLS_LS_IND  = 2'b10;

    // Reserved ALU op codes; the decoder sign-extends them so they stay the
    // top codes of the op field whatever its width.
    localparam logic [4:0] OP_MOV  = 5'b11111;
    localparam logic [4:0] OP_INC  = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11101;

    // Jump conditions on flag bit 0
    localparam logic [1:0] JC_ALWAYS = 2'b00;
    localparam logic [1:0] JC_IF_CLR = 2'b01;
    localparam logic [1:0] JC_IF_SET = 2'b10;
    localparam logic [1:0] JC_NEVER  = 2'b11;

    // Read/write encoding and the inactive levels of the RW-style strobes
    localparam logic RW_READ          = 1'b1;
    localparam logic RW_WRITE         = 1'b0;
    localparam logic PC_RW_IDLE       = RW_READ;
    localparam logic RAM_RW_IDLE      = RW_READ;
    localparam logic REGS_RW_IDLE_BIT = RW_READ;
    localparam logic MAR_EN_IDLE      = 1'b1;

    // Accumulator register indices
    localparam int REG_A = 0;
    localparam int REG_B = 1;

endpackage

// File: rtl/bat_instr_decode.sv
// Pure combinational instruction decoder: class, register fields and jump outcome.
module bat_instr_decode
    import bat_pkg::*;
#(
    parameter int  REG_SEL_W = 3,
    parameter int  ALU_OP_W  = 5,
    localparam int INSTR_W   = 4 + ALU_OP_W + 1 + 2 * REG_SEL_W
) (
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 flag,
    output instr_class_e         cls,
    output logic [REG_SEL_W-1:0] r1,
    output logic [REG_SEL_W-1:0] r2,
    output logic [REG_SEL_W-1:0] dest,
    output logic [REG_SEL_W-1:0] regsel,
    output logic                 store,
    output logic                 jump_taken
);
    localparam int TOP = INSTR_W - 1;
    localparam logic [ALU_OP_W-1:0] MOV_CODE  = ALU_OP_W'($signed(OP_MOV));
    localparam logic [ALU_OP_W-1:0] INC_CODE  = ALU_OP_W'($signed(OP_INC));
    localparam logic [ALU_OP_W-1:0] HALT_CODE = ALU_OP_W'($signed(OP_HALT));

    logic [ALU_OP_W-1:0] op;
    logic [1:0]          cond;

    // Field extraction, condition evaluation and priority class decode
    always_comb begin
        op     = instr[TOP-4 -: ALU_OP_W];
        cond   = instr[TOP-2 -: 2];
        r1     = instr[2*REG_SEL_W-1 -: REG_SEL_W];
        r2     = instr[REG_SEL_W-1:0];
        dest   = instr[2*REG_SEL_W] ? REG_SEL_W'(REG_A) : REG_SEL_W'(REG_B);
        regsel = instr[TOP-3] ? REG_SEL_W'(REG_B) : REG_SEL_W'(REG_A);
        store  = instr[TOP-2];

        case (cond)
            JC_ALWAYS: jump_taken = 1'b1;
            JC_IF_CLR: jump_taken = ~flag;
            JC_IF_SET: jump_taken = flag;
            default:   jump_taken = 1'b0;
        endcase

        if (instr[TOP -: 4] == CLASS_ALU) begin
            if (op == MOV_CODE)       cls = CL_MOV;
            else if (op == INC_CODE)  cls = CL_INC;
            else if (op == HALT_CODE) cls = CL_HALT;
            else                      cls = CL_ALU;
        end else begin
            case (instr[TOP -: 2])
                CLS_JMP_DIR: cls = CL_JMP_DIR;
                CLS_LS_DIR:  cls = CL_LS_DIR;
                CLS_JMP_IND: cls = CL_JMP_IND;
                default:     cls = CL_LS_IND;
            endcase
        end
    end

endmodule

// File: rtl/bat_microsequencer.sv
// BatAmateur bus-CPU control unit: fetch/decode/execute sequencer with
// memory wait states, HALT and status outputs.
module bat_microsequencer
    import bat_pkg::*;
#(
    parameter int  REG_SEL_W = 3,
    parameter int  ALU_OP_W  = 5,
    parameter int  FLAG_W    = 8,
    localparam int NUM_REGS  = 2 ** REG_SEL_W,
    localparam int INSTR_W   = 4 + ALU_OP_W + 1 + 2 * REG_SEL_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [INSTR_W-1:0]  INSTR,
    input  logic [FLAG_W-1:0]   ALU_REG,
    input  logic                MEM_READY,
    output logic                PC_INC,
    output logic                PC_RW,
    output logic                PC_EN,
    output logic                MAR_LOAD,
    output logic                MAR_EN,
    output logic                RAM_RW,
    output logic                RAM_EN,
    output logic                IR_LOAD,
    output logic                IR_EN,
    output logic [NUM_REGS-1:0] REGS_INC,
    output logic [NUM_REGS-1:0] REGS_RW,
    output logic [NUM_REGS-1:0] REGS_EN,
    output logic                ALU_EN,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                HALTED,
    output logic                INSTR_DONE
);
    localparam logic [NUM_REGS-1:0] REGS_RW_IDLE = {NUM_REGS{REGS_RW_IDLE_BIT}};

    state_e               state_q, state_d;
    instr_class_e         cls;
    logic [REG_SEL_W-1:0] r1, r2, dest, regsel;
    logic                 store, jump_taken;
    logic                 xfer;
    logic                 unused_flags;

    // Only flag bit 0 steers the sequencer; the rest belongs to the ALU
    assign unused_flags = ^ALU_REG;

    bat_instr_decode #(
        .REG_SEL_W(REG_SEL_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .instr     (INSTR),
        .flag      (ALU_REG[0]),
        .cls       (cls),
        .r1        (r1),
        .r2        (r2),
        .dest      (dest),
        .regsel    (regsel),
        .store     (store),
        .jump_taken(jump_taken)
    );

    // State register; the synchronous reset is folded into state_d
    always_ff @(posedge CLK) begin
        state_q <= state_d;
    end

    // Next state: RAM-accessing states hold until MEM_READY
    always_comb begin
        state_d = state_q;
        if (!RST) begin
            state_d = ST_FETCH_ADDR;
        end else begin
            case (state_q)
                ST_FETCH_ADDR: state_d = ST_FETCH_IR;
                ST_FETCH_IR:   if (MEM_READY) state_d = ST_DECODE;
                ST_DECODE: begin
                    case (cls)
                        CL_MOV, CL_INC, CL_JMP_DIR: state_d = ST_FETCH_ADDR;
                        CL_HALT:                    state_d = ST_HALT;
                        default:                    state_d = ST_EXEC1;
                    endcase
                end
                ST_EXEC1: begin
                    case (cls)
                        CL_ALU:     state_d = ST_EXEC2;
                        CL_LS_IND:  if (MEM_READY) state_d = ST_EXEC2;
                        CL_LS_DIR:  if (MEM_READY) state_d = ST_FETCH_ADDR;
                        CL_JMP_IND: if (MEM_READY || !jump_taken) state_d = ST_FETCH_ADDR;
                        default:    state_d = ST_FETCH_ADDR;
                    endcase
                end
                ST_EXEC2: begin
                    if (cls != CL_LS_IND || MEM_READY) state_d = ST_FETCH_ADDR;
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_FETCH_ADDR;
            endcase
        end
    end

    // Control strobes: inactive defaults, per-state decode, shared RAM transfer
    always_comb begin
        PC_INC     = 1'b0;
        PC_RW      = PC_RW_IDLE;
        PC_EN      = 1'b0;
        MAR_LOAD   = 1'b0;
        MAR_EN     = MAR_EN_IDLE;
        RAM_RW     = RAM_RW_IDLE;
        RAM_EN     = 1'b0;
        IR_LOAD    = 1'b0;
        IR_EN      = 1'b0;
        REGS_INC   = '0;
        REGS_RW    = REGS_RW_IDLE;
        REGS_EN    = '0;
        ALU_EN     = 1'b0;
        ALU_OP     = '0;
        HALTED     = 1'b0;
        INSTR_DONE = 1'b0;
        xfer       = 1'b0;
        if (RST) begin
            case (state_q)
                ST_FETCH_ADDR: begin
                    PC_EN    = 1'b1;
                    MAR_LOAD = 1'b1;
                end
                ST_FETCH_IR: begin
                    RAM_EN  = 1'b1;
                    IR_LOAD = MEM_READY;
                    PC_INC  = MEM_READY;
                end
                ST_DECODE: begin
                    case (cls)
                        CL_MOV: begin
                            REGS_EN[r2] = 1'b1;
                            REGS_EN[r1] = 1'b1;
                            REGS_RW[r1] = RW_WRITE;
                            INSTR_DONE  = 1'b1;
                        end
                        CL_INC: begin
                            REGS_INC[r1] = 1'b1;
                            INSTR_DONE   = 1'b1;
                        end
                        CL_HALT: INSTR_DONE = 1'b1;
                        CL_ALU: begin
                            // Operand 1 already in A needs no move
                            if (r1 != REG_SEL_W'(REG_A)) begin
                                REGS_EN[r1]    = 1'b1;
                                REGS_EN[REG_A] = 1'b1;
                                REGS_RW[REG_A] = RW_WRITE;
                            end
                        end
                        CL_JMP_DIR: begin
                            // Untaken: PC was already advanced by the fetch
                            if (jump_taken) begin
                                IR_EN = 1'b1;
                                PC_EN = 1'b1;
                                PC_RW = RW_WRITE;
                            end
                            INSTR_DONE = 1'b1;
                        end
                        default: begin
                            IR_EN    = 1'b1;
                            MAR_LOAD = 1'b1;
                        end
                    endcase
                end
                ST_EXEC1: begin
                    case (cls)
                        CL_ALU: begin
                            if (r2 != REG_SEL_W'(REG_B)) begin
                                REGS_EN[r2]    = 1'b1;
                                REGS_EN[REG_B] = 1'b1;
                                REGS_RW[REG_B] = RW_WRITE;
                            end
                        end
                        CL_LS_DIR: xfer = 1'b1;
                        CL_JMP_IND: begin
                            if (jump_taken) begin
                                RAM_EN     = 1'b1;
                                PC_RW      = RW_WRITE;
                                PC_EN      = MEM_READY;
                                INSTR_DONE = MEM_READY;
                            end else begin
                                INSTR_DONE = 1'b1;
                            end
                        end
                        CL_LS_IND: begin
                            // Pointer word from RAM replaces the MAR contents
                            RAM_EN   = 1'b1;
                            MAR_LOAD = MEM_READY;
                        end
                        default: ;
                    endcase
                end
                ST_EXEC2: begin
                    if (cls == CL_LS_IND) begin
                        xfer = 1'b1;
                    end else begin
                        ALU_EN        = 1'b1;
                        ALU_OP        = INSTR[INSTR_W-5 -: ALU_OP_W];
                        REGS_EN[dest] = 1'b1;
                        REGS_RW[dest] = RW_WRITE;
                        INSTR_DONE    = 1'b1;
                    end
                end
                ST_HALT: HALTED = 1'b1;
                default: ;
            endcase

            // RAM<->accumulator transfer: a storing register drives the bus for
            // the whole wait; a loading register is written only when data lands.
            if (xfer) begin
                RAM_EN = 1'b1;
                if (store) begin
                    RAM_RW          = RW_WRITE;
                    REGS_EN[regsel] = 1'b1;
                end else begin
                    REGS_EN[regsel] = MEM_READY;
                    REGS_RW[regsel] = MEM_READY ? RW_WRITE : RW_READ;
                end
                INSTR_DONE = MEM_READY;
            end
        end
    end

endmodule

// File: tb/tb_bat_microsequencer.sv
// Directed self-checking bench for bat_microsequencer (default parameters).
module tb_bat_microsequencer;

    typedef struct packed {
        logic       pc_inc, pc_rw, pc_en, mar_load, mar_en, ram_rw, ram_en, ir_load, ir_en;
        logic [7:0] regs_inc, regs_rw, regs_en;
        logic       alu_en;
        logic [4:0] alu_op;
        logic       halted, instr_done;
    } outs_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] INSTR = '0;
    logic [7:0]  ALU_REG = '0;
    logic        MEM_READY = 1'b1;
    logic        PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN;
    logic [7:0]  REGS_INC, REGS_RW, REGS_EN;
    logic        ALU_EN;
    logic [4:0]  ALU_OP;
    logic        HALTED, INSTR_DONE;
    outs_t       obs;
    int          n_cmp = 0;
    int          n_err = 0;

    bat_microsequencer dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .ALU_REG(ALU_REG), .MEM_READY(MEM_READY),
        .PC_INC(PC_INC), .PC_RW(PC_RW), .PC_EN(PC_EN), .MAR_LOAD(MAR_LOAD), .MAR_EN(MAR_EN),
        .RAM_RW(RAM_RW), .RAM_EN(RAM_EN), .IR_LOAD(IR_LOAD), .IR_EN(IR_EN),
        .REGS_INC(REGS_INC), .REGS_RW(REGS_RW), .REGS_EN(REGS_EN),
        .ALU_EN(ALU_EN), .ALU_OP(ALU_OP), .HALTED(HALTED), .INSTR_DONE(INSTR_DONE)
    );

    always #5 CLK = ~CLK;

    assign obs = {PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN, IR_LOAD, IR_EN,
                  REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP, HALTED, INSTR_DONE};

    function automatic outs_t idle_o();
        outs_t o;
        o = '0;
        o.pc_rw = 1'b1; o.mar_en = 1'b1; o.ram_rw = 1'b1; o.regs_rw = 8'hFF;
        return o;
    endfunction

    function automatic outs_t fa_o();
        outs_t o;
        o = idle_o();
        o.pc_en = 1'b1; o.mar_load = 1'b1;
        return o;
    endfunction

    function automatic outs_t fi_o();
        outs_t o;
        o = idle_o();
        o.ram_en = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1;
        return o;
    endfunction

    // Hold reset for two edges, release at a falling edge: DUT sits in FETCH_ADDR
    task automatic reset_dut();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; INSTR = 16'h7F8A; MEM_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1; n_cmp++;
            if (obs !== idle_o()) begin
                n_err++; $display("FAIL reset c%0d: got %h want %h", k, obs, idle_o());
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_mov();
        outs_t e [4];
        INSTR = 16'h7F8A; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = fa_o();
        e[2].regs_en = 8'h06; e[2].regs_rw = 8'hFD; e[2].instr_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL mov c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_inc();
        outs_t e [4];
        INSTR = 16'h7F18; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = fa_o();
        e[2].regs_inc = 8'h08; e[2].instr_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL inc c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_alu();
        outs_t e [6];
        INSTR = 16'h71DC; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = idle_o(); e[4] = idle_o(); e[5] = fa_o();
        e[2].regs_en = 8'h09; e[2].regs_rw = 8'hFE;
        e[3].regs_en = 8'h12; e[3].regs_rw = 8'hFD;
        e[4].alu_en = 1'b1; e[4].alu_op = 5'd3; e[4].regs_en = 8'h01; e[4].regs_rw = 8'hFE;
        e[4].instr_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL alu c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_jump();
        logic [15:0] ins [3] = '{16'h5000, 16'h5000, 16'h6000};
        logic [7:0]  flg [3] = '{8'h00, 8'h01, 8'h01};
        bit          tkn [3] = '{1'b1, 1'b0, 1'b1};
        outs_t       e [4];
        for (int v = 0; v < 3; v++) begin
            INSTR = ins[v]; ALU_REG = flg[v]; MEM_READY = 1'b1;
            reset_dut();
            e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = fa_o();
            e[2].instr_done = 1'b1;
            if (tkn[v]) begin
                e[2].ir_en = 1'b1; e[2].pc_en = 1'b1; e[2].pc_rw = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                #1; n_cmp++;
                if (obs !== e[k]) begin
                    n_err++; $display("FAIL jump%0d c%0d: got %h want %h", v, k + 1, obs, e[k]);
                end
                @(negedge CLK);
            end
        end
        ALU_REG = '0;
    endtask

    task automatic test_mem_wait();
        bit    rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        outs_t e [7];
        outs_t w;
        INSTR = 16'h7F8A; MEM_READY = 1'b1;
        reset_dut();
        w = idle_o(); w.ram_en = 1'b1;
        e[0] = fa_o(); e[1] = w; e[2] = w; e[3] = w; e[4] = fi_o(); e[5] = idle_o(); e[6] = fa_o();
        e[5].regs_en = 8'h06; e[5].regs_rw = 8'hFD; e[5].instr_done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            MEM_READY = rdy[k];
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL mem_wait c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
        MEM_READY = 1'b1;
    endtask

    task automatic test_indirect_load();
        outs_t e [6];
        INSTR = 16'h9000; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = idle_o(); e[4] = idle_o(); e[5] = fa_o();
        e[2].ir_en = 1'b1; e[2].mar_load = 1'b1;
        e[3].ram_en = 1'b1; e[3].mar_load = 1'b1;
        e[4].ram_en = 1'b1; e[4].regs_en = 8'h02; e[4].regs_rw = 8'hFD; e[4].instr_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL ind_load c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_store_wait();
        bit    rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        outs_t e [6];
        INSTR = 16'h2000; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = idle_o(); e[5] = fa_o();
        e[2].ir_en = 1'b1; e[2].mar_load = 1'b1;
        e[3].ram_en = 1'b1; e[3].ram_rw = 1'b0; e[3].regs_en = 8'h01;
        e[4] = e[3]; e[4].instr_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            MEM_READY = rdy[k];
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL store_wait c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
        MEM_READY = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit    rs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        outs_t e [6];
        INSTR = 16'h71DC; MEM_READY = 1'b1;
        reset_dut();
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[3] = idle_o(); e[4] = fa_o(); e[5] = fi_o();
        e[2].regs_en = 8'h09; e[2].regs_rw = 8'hFE;
        for (int k = 0; k < 6; k++) begin
            RST = rs[k];
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL reset_mid c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
    endtask

    task automatic test_halt();
        bit    rs [26];
        outs_t e [26];
        INSTR = 16'h7E80; MEM_READY = 1'b1;
        reset_dut();
        for (int k = 0; k < 26; k++) begin
            rs[k] = 1'b1;
            e[k] = idle_o();
            e[k].halted = 1'b1;
        end
        e[0] = fa_o(); e[1] = fi_o(); e[2] = idle_o(); e[2].instr_done = 1'b1;
        rs[23] = 1'b0; e[23] = idle_o();
        e[24] = fa_o(); e[25] = fi_o();
        for (int k = 0; k < 26; k++) begin
            RST = rs[k];
            #1; n_cmp++;
            if (obs !== e[k]) begin
                n_err++; $display("FAIL halt c%0d: got %h want %h", k + 1, obs, e[k]);
            end
            @(negedge CLK);
        end
        RST = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_mov();
        test_inc();
        test_alu();
        test_jump();
        test_mem_wait();
        test_indirect_load();
        test_store_wait();
        test_reset_mid();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
